// File: rtl/frame_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_pingpong_ctrl
// Description : Word-slot timer and ping-pong frame scheduler. Generates the
//               word strobe and write pulse/address into a two-bank frame
//               memory, hands each completed bank to a reader through a
//               request/done handshake, and flags overruns.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pingpong_ctrl #(
    parameter int WORDS  = 20,
    parameter int AW     = 5,
    parameter int PERIOD = 16,
    parameter int WE_DLY = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          strob,
    output logic [AW:0]   wrAdr,
    output logic          WE,
    output logic          frmRdy,
    input  logic          rdReq,
    output logic [AW:0]   rdAdr,
    output logic          rdVal,
    output logic          rdDone,
    output logic          ovf,
    input  logic          ovfClr
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [TW-1:0] TMR_LAST   = TW'(PERIOD - 1);
    localparam logic [TW-1:0] TMR_HALF   = TW'(PERIOD / 2);
    localparam logic [TW-1:0] TMR_WE     = TW'(WE_DLY);
    localparam logic [AW-1:0] WORD_LAST  = AW'(WORDS - 1);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_RUN  = 2'd1;
    localparam logic [1:0] R_DONE = 2'd2;

    logic [TW-1:0] tmr;
    logic [AW-1:0] wr_idx;
    logic          wr_bank;
    logic [AW-1:0] rd_idx;
    logic          rd_bank;
    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic          frame_end;
    logic          handoff;
    logic          overrun;

    // A frame completes on the WE of its last word; the bank may only be
    // handed over when the reader holds nothing or is releasing it now.
    assign frame_end = WE && (wr_idx == WORD_LAST);
    assign handoff   = frame_end && (!frmRdy || (state == R_DONE));
    assign overrun   = frame_end && !handoff;

    assign wrAdr = {wr_bank, wr_idx};
    assign rdAdr = {rd_bank, rd_idx};

    // Slot timer: free-running modulo PERIOD while enabled, parked at 0 otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (!en) begin
            tmr <= '0;
        end else if (tmr == TMR_LAST) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 1'b1;
        end
    end

    // Registered strobe and write pulse, both decoded from the slot timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strob <= 1'b0;
            WE    <= 1'b0;
        end else begin
            strob <= en && (tmr < TMR_HALF);
            WE    <= en && (tmr == TMR_WE);
        end
    end

    // Write word/bank sequencing; an overrun rewrites the same bank from word 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (WE) begin
            if (frame_end) begin
                wr_idx <= '0;
                if (handoff) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Handoff bookkeeping: reader bank, ready level (set beats clear), overrun flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank <= 1'b0;
            frmRdy  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (handoff) begin
                rd_bank <= wr_bank;
            end
            if (handoff) begin
                frmRdy <= 1'b1;
            end else if (state == R_DONE) begin
                frmRdy <= 1'b0;
            end
            if (overrun) begin
                ovf <= 1'b1;
            end else if (ovfClr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= R_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM next-state: a request is only honoured when a bank is waiting
    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE:  if (rdReq && frmRdy) state_nxt = R_RUN;
            R_RUN:   if (rd_idx == WORD_LAST) state_nxt = R_DONE;
            R_DONE:  state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs, decoded from the state register only
    always_comb begin
        rdVal  = 1'b0;
        rdDone = 1'b0;
        case (state)
            R_RUN:   rdVal  = 1'b1;
            R_DONE:  rdDone = 1'b1;
            default: ;
        endcase
    end

    // Read word index: cleared on burst start, stepped every burst clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_idx <= '0;
        end else if (state == R_RUN) begin
            rd_idx <= (rd_idx == WORD_LAST) ? '0 : rd_idx + 1'b1;
        end else if (state_nxt == R_RUN) begin
            rd_idx <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_pingpong_ctrl
// Description : Self-checking bench for frame_pingpong_ctrl. A behavioural
//               model (slot phase, frame word count, waiting-bank flag,
//               reader burst position) predicts every output each clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_pingpong_ctrl;

    localparam int WORDS  = 20;
    localparam int AW     = 5;
    localparam int PERIOD = 16;
    localparam int WE_DLY = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          rdReq = 1'b0;
    logic          ovfClr = 1'b0;
    logic          strob;
    logic [AW:0]   wrAdr;
    logic          WE;
    logic          frmRdy;
    logic [AW:0]   rdAdr;
    logic          rdVal;
    logic          rdDone;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_phase;
    int m_word;
    int m_wbank;
    int m_rbank;
    int m_rpos;      // -1 idle, 0..WORDS-1 burst word, WORDS = done clock
    bit e_strob, e_we, e_frmrdy, e_rdval, e_rddone, e_ovf;

    frame_pingpong_ctrl #(
        .WORDS  (WORDS),
        .AW     (AW),
        .PERIOD (PERIOD),
        .WE_DLY (WE_DLY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .strob  (strob),
        .wrAdr  (wrAdr),
        .WE     (WE),
        .frmRdy (frmRdy),
        .rdReq  (rdReq),
        .rdAdr  (rdAdr),
        .rdVal  (rdVal),
        .rdDone (rdDone),
        .ovf    (ovf),
        .ovfClr (ovfClr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase  = 0;
        m_word   = 0;
        m_wbank  = 0;
        m_rbank  = 0;
        m_rpos   = -1;
        e_strob  = 0;
        e_we     = 0;
        e_frmrdy = 0;
        e_rdval  = 0;
        e_rddone = 0;
        e_ovf    = 0;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        bit set_ready;
        bit overrun;
        bit rdy_next;
        set_ready = 0;
        overrun   = 0;
        if (e_we) begin
            if (m_word < WORDS - 1) begin
                m_word++;
            end else begin
                m_word = 0;
                if (!e_frmrdy || e_rddone) begin
                    m_rbank   = m_wbank;
                    m_wbank   = 1 - m_wbank;
                    set_ready = 1;
                end else begin
                    overrun = 1;
                end
            end
        end
        rdy_next = e_frmrdy;
        if (m_rpos == WORDS) begin
            m_rpos   = -1;
            rdy_next = 0;
        end else if (m_rpos >= 0) begin
            m_rpos++;
        end else if (rdReq && e_frmrdy) begin
            m_rpos = 0;
        end
        if (set_ready) rdy_next = 1;
        e_frmrdy = rdy_next;
        if (overrun) e_ovf = 1;
        else if (ovfClr) e_ovf = 0;
        e_strob  = en && (m_phase < PERIOD / 2);
        e_we     = en && (m_phase == WE_DLY);
        m_phase  = en ? (m_phase + 1) % PERIOD : 0;
        e_rdval  = (m_rpos >= 0) && (m_rpos < WORDS);
        e_rddone = (m_rpos == WORDS);
    endtask

    task automatic check_all();
        chk("strob",  strob,  e_strob);
        chk("WE",     WE,     e_we);
        chk("wrAdr",  wrAdr,  (m_wbank << AW) + m_word);
        chk("frmRdy", frmRdy, e_frmrdy);
        chk("rdVal",  rdVal,  e_rdval);
        chk("rdDone", rdDone, e_rddone);
        chk("ovf",    ovf,    e_ovf);
        if (e_rdval) chk("rdAdr", rdAdr, (m_rbank << AW) + m_rpos);
    endtask

    task automatic cycle();
        if (rst) model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset_rdAdr", rdAdr, 0);
    endtask

    initial begin
        int  guard;
        bit  timed_out;
        bit  gap_seen;

        // Reset and idle with en low
        model_reset();
        #2;
        check_all();
        chk("reset_rdAdr", rdAdr, 0);
        run(3);
        rst = 1'b1;
        run(100);

        // First frame into bank 0
        en = 1'b1;
        run(WORDS * PERIOD + 5);
        chk("frame1_ready", frmRdy, 1);
        chk("frame1_next_wradr", wrAdr, 32);

        // Read back bank 0
        rdReq = 1'b1;
        cycle();
        rdReq = 1'b0;
        chk("read0_first_adr", rdAdr, 0);
        run(WORDS + 2);
        chk("read0_released", frmRdy, 0);

        // Second frame lands in bank 1 and is read from there
        run(300);
        rdReq = 1'b1;
        cycle();
        rdReq = 1'b0;
        chk("read1_first_adr", rdAdr, 32);
        run(25);

        // No reader: third frame hands off, fourth overruns
        run(611);
        chk("overrun_flag", ovf, 1);
        chk("overrun_bank_kept", wrAdr, 32);
        ovfClr = 1'b1;
        cycle();
        ovfClr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // Reader's done clock coincides with the last WE of a frame
        timed_out = 1;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (e_we && m_word == WORDS - 3) begin
                timed_out = 0;
                break;
            end
        end
        chk("wait_word17", timed_out, 0);
        run(11);
        rdReq = 1'b1;
        cycle();
        rdReq = 1'b0;
        run(19);
        cycle();
        chk("boundary_rddone", rdDone, 1);
        chk("boundary_we", WE, 1);
        cycle();
        chk("boundary_ready_kept", frmRdy, 1);
        chk("boundary_no_ovf", ovf, 0);

        // Drop en while the writer sits at word 7
        timed_out = 1;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (m_word == 7 && !e_we) begin
                timed_out = 0;
                break;
            end
        end
        chk("wait_word7", timed_out, 0);
        run(3);
        en = 1'b0;
        gap_seen = 0;
        cycle();
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (strob || WE) gap_seen = 1;
        end
        chk("gap_quiet", gap_seen, 0);
        en = 1'b1;
        run(14);
        chk("resume_we", WE, 1);
        chk("resume_word7", wrAdr[AW-1:0], 7);
        run(20);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            en     = ($urandom_range(0, 19) != 0);
            rdReq  = ($urandom_range(0, 29) == 0);
            ovfClr = ($urandom_range(0, 49) == 0);
            cycle();
        end
        en     = 1'b1;
        rdReq  = 1'b0;
        ovfClr = 1'b0;

        // Reset in the middle of a readout burst
        timed_out = 1;
        for (int i = 0; i < 2000; i++) begin
            cycle();
            if (e_frmrdy && m_rpos == -1) begin
                timed_out = 0;
                break;
            end
        end
        chk("wait_ready", timed_out, 0);
        rdReq = 1'b1;
        cycle();
        rdReq = 1'b0;
        run(5);
        chk("midread_rdval", rdVal, 1);
        async_reset();
        chk("rst_rdval", rdVal, 0);
        chk("rst_frmrdy", frmRdy, 0);
        run(2);
        rst = 1'b1;
        run(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_pingpong_ctrl.md
# frame_pingpong_ctrl

Frame scheduler for the word commutator datapath. It generates the periodic word strobe and the per-word write address and write-enable into a two-bank (ping-pong) frame memory of WORDS words per bank. When a bank is complete it hands that bank to a downstream reader through a request/done handshake. It sits between the sensor-word source and the frame readout/transmit logic, and guarantees the reader never sees a bank that is being written.

## Interface
Parameters:
- WORDS, 20: words per frame (bank); must be ≥2.
- AW, 5: word index width; 2^AW ≥ WORDS.
- PERIOD, 16: clocks per word slot; even, ≥4.
- WE_DLY, 13: clocks from strob rise to WE pulse; 1 ≤ WE_DLY ≤ PERIOD-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  enables word-slot generation.
- strob  out  1  word strobe to the source, high for the first PERIOD/2 clocks of each slot.
- wrAdr  out  AW+1  write address {wrBank, wrIdx}.
- WE  out  1  one-clock write pulse.
- frmRdy  out  1  level; a completed bank is waiting or being read.
- rdReq  in  1  reader start request, sampled each clock.
- rdAdr  out  AW+1  read address {rdBank, rdIdx}.
- rdVal  out  1  rdAdr valid this clock.
- rdDone  out  1  one-clock pulse at end of bank readout.
- ovf  out  1  sticky overrun flag.
- ovfClr  in  1  clears ovf.

## Operation
Reset values: every output is 0, timer = 0, wrBank = 0, wrIdx = 0, rdBank = 0, rdIdx = 0, read FSM in R_IDLE.

Slot timer `tmr` (0..PERIOD-1):
- While en = 1, tmr increments and wraps from PERIOD-1 to 0.
- While en = 0, tmr is forced to 0, strob = 0 and no WE is issued. wrIdx and wrBank hold, so a partial frame resumes when en returns.
- strob = en && (tmr < PERIOD/2), registered.
- WE = 1 for exactly one clock when tmr == WE_DLY. wrAdr is stable during the whole slot.

Write sequencing on each WE:
- If wrIdx < WORDS-1: wrIdx + 1 on the clock after WE.
- If wrIdx == WORDS-1 (frame complete): wrIdx goes to 0. Then exactly one of:
  - Handoff. Condition: frmRdy == 0, or the read FSM is in R_DONE this clock. Action: rdBank <= wrBank, wrBank toggles, frmRdy <= 1.
  - Overrun (all other cases). Action: ovf <= 1; wrBank unchanged, so the bank is rewritten from word 0 and the frame is discarded.

Read FSM:
- R_IDLE: if rdReq && frmRdy, go to R_RUN with rdIdx = 0. rdReq while frmRdy = 0 is ignored and not queued.
- R_RUN: rdVal = 1 and rdAdr = {rdBank, rdIdx}. rdIdx increments each clock. After the word with rdIdx == WORDS-1, go to R_DONE.
- R_DONE: rdDone = 1 for one clock, rdVal = 0, frmRdy <= 0 (unless a handoff sets it in the same clock; set wins). Return to R_IDLE.
- rdReq outside R_IDLE is ignored.

Flags:
- ovf is cleared by ovfClr. If an overrun and ovfClr occur in the same clock, the set wins.
- Asserting reset mid-frame or mid-read immediately returns all state to reset values. Any partial frame and any pending bank are dropped.

## Timing
- strob rises on the clock after tmr reaches 0, i.e. one registered stage after the slot start.
- WE lands WE_DLY clocks after the strob rise.
- Frame period = WORDS·PERIOD clocks (320 at defaults).
- frmRdy rises on the clock after the last WE of a frame.
- rdReq to first rdVal: 1 clock. Readout burst is WORDS consecutive clocks. rdDone comes 1 clock after the last rdVal.
- Reader deadline: to avoid overrun, readout must reach R_DONE no later than the last WE of the next frame.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: rst = 0 then released with en = 0 → all outputs stay 0 for 100 clocks.
- Single frame: en = 1 at defaults → 20 WE pulses, each 13 clocks after a strob rise, 16 clocks apart, wrAdr 0..19; frmRdy = 1 one clock after the 20th WE; wrAdr next shows bank 1, word 0.
- Readout: rdReq pulse with frmRdy = 1 → rdVal for 20 consecutive clocks, rdAdr 0..19 with bank bit 0; rdDone pulse; frmRdy = 0; next frame is handed off from bank 1 (rdAdr 32..51).
- Overrun: never assert rdReq → second frame completion sets ovf = 1 and wrBank stays 1; ovfClr pulse drops ovf.
- Boundary: timed so R_DONE coincides with the last WE of a frame → handoff taken, frmRdy stays 1, ovf stays 0.
- Mid-operation: en dropped at word 7 for 50 clocks → no strob/WE during the gap, resumes at word 7. A separate run asserts rst during R_RUN → rdVal and frmRdy are 0 immediately.
